// File: rtl/lock_keypad_pkg.sv
// Shared types for the door-lock slice: the lock FSM states and the keypad
// front-end states, plus a small constant helper.
package lock_keypad_pkg;

   typedef enum logic [1:0] {
      LOCK_CLOSED  = 2'd0,
      LOCK_OPENING = 2'd1,
      LOCK_OPEN    = 2'd2,
      LOCK_CLOSING = 2'd3
   } lock_state;

   typedef enum logic [1:0] {
      KEYPAD_IDLE     = 2'd0,
      KEYPAD_ENTRY    = 2'd1,
      KEYPAD_UNLOCKED = 2'd2,
      KEYPAD_LOCKOUT  = 2'd3
   } keypad_state;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lock_keypad_timer.sv
// Clearable free-running up-counter with a compare-against-terminal flag,
// shared by the lockout and auto-close windows.
module lock_keypad_timer
   import lock_keypad_pkg::*;
#(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_tc_val,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) r_count <= '0;
      else              r_count <= r_count + 1'b1;
   end

   assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/lock_keypad.sv
// Keypad code-entry controller: collects digits, checks them against the
// stored code and issues one-cycle open/close pulses to the lock FSM.
module lock_keypad
   import lock_keypad_pkg::*;
#(
   parameter int unsigned                  CODE_LEN          = 4,
   parameter int unsigned                  DIGIT_W           = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE      = 16'h1234,
   parameter int unsigned                  MAX_FAIL          = 3,
   parameter int unsigned                  LOCKOUT_CYCLES    = 16,
   parameter int unsigned                  AUTO_CLOSE_CYCLES = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            digit_valid,
   input  logic [DIGIT_W-1:0]              digit,
   input  logic                            enter,
   input  logic                            cancel,
   input  logic                            close_req,
   input  logic                            code_wr,
   input  logic [CODE_LEN*DIGIT_W-1:0]     code_wr_data,
   output logic                            open,
   output logic                            close,
   output logic                            locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

   localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
   localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
   localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int unsigned TIMER_W = $clog2(max_u(LOCKOUT_CYCLES, AUTO_CLOSE_CYCLES));

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CODE_LEN);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

   keypad_state         r_state;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   r_buf;
   logic [CNT_W-1:0]    r_count;
   logic                r_overflow;
   logic                r_open;
   logic                r_close;
   logic                r_locked_out;
   logic [FAIL_W-1:0]   r_fail;

   logic                w_match;
   logic                w_code_wr;
   logic                w_timer_clr;
   logic                w_tc;
   logic [TIMER_W-1:0]  w_tc_val;

   assign w_match     = (r_count == CNT_FULL) && !r_overflow && (r_buf == r_code);
   assign w_code_wr   = (r_state == KEYPAD_UNLOCKED) && code_wr;
   // Timer idles at zero outside the timed states, so entering one starts it from 0.
   assign w_timer_clr = !((r_state == KEYPAD_UNLOCKED) || (r_state == KEYPAD_LOCKOUT)) || w_code_wr;
   assign w_tc_val    = (r_state == KEYPAD_LOCKOUT) ? TIMER_W'(LOCKOUT_CYCLES - 1)
                                                    : TIMER_W'(AUTO_CLOSE_CYCLES - 1);

   lock_keypad_timer #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_timer_clr),
      .i_tc_val (w_tc_val),
      .o_tc     (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= KEYPAD_IDLE;
         r_code       <= DEFAULT_CODE;
         r_buf        <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_open       <= 1'b0;
         r_close      <= 1'b0;
         r_locked_out <= 1'b0;
         r_fail       <= '0;
      end else begin
         r_open  <= 1'b0;
         r_close <= 1'b0;
         case (r_state)
            KEYPAD_IDLE, KEYPAD_ENTRY: begin
               if (cancel) begin
                  r_buf      <= '0;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
                  r_state    <= KEYPAD_IDLE;
               end else if (enter) begin
                  r_buf      <= '0;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
                  if (w_match) begin
                     r_open  <= 1'b1;
                     r_fail  <= '0;
                     r_state <= KEYPAD_UNLOCKED;
                  end else if (r_fail == FAIL_LAST) begin
                     r_fail       <= FAIL_MAX;
                     r_locked_out <= 1'b1;
                     r_state      <= KEYPAD_LOCKOUT;
                  end else begin
                     r_fail  <= r_fail + 1'b1;
                     r_state <= KEYPAD_IDLE;
                  end
               end else if (digit_valid) begin
                  r_buf <= {r_buf[CODE_W-DIGIT_W-1:0], digit};
                  if (r_count == CNT_FULL) r_overflow <= 1'b1;
                  else                     r_count    <= r_count + 1'b1;
                  r_state <= KEYPAD_ENTRY;
               end
            end
            KEYPAD_UNLOCKED: begin
               if (code_wr) r_code <= code_wr_data;
               if (close_req || w_tc) begin
                  r_close <= 1'b1;
                  r_state <= KEYPAD_IDLE;
               end
            end
            KEYPAD_LOCKOUT: begin
               if (w_tc) begin
                  r_locked_out <= 1'b0;
                  r_fail       <= '0;
                  r_state      <= KEYPAD_IDLE;
               end
            end
            default: r_state <= KEYPAD_IDLE;
         endcase
      end
   end

   assign open       = r_open;
   assign close      = r_close;
   assign locked_out = r_locked_out;
   assign fail_count = r_fail;

endmodule

// File: tb/tb_lock_keypad.sv
// Directed bench for lock_keypad: code match, failures and lockout, overflow,
// cancel, auto-close, code rewrite, input priority and reset recovery.
module tb_lock_keypad;

   logic        clk;
   logic        rst;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        enter;
   logic        cancel;
   logic        close_req;
   logic        code_wr;
   logic [15:0] code_wr_data;
   logic        open;
   logic        close;
   logic        locked_out;
   logic [1:0]  fail_count;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   lock_keypad #(
      .CODE_LEN          (4),
      .DIGIT_W           (4),
      .DEFAULT_CODE      (16'h1234),
      .MAX_FAIL          (3),
      .LOCKOUT_CYCLES    (16),
      .AUTO_CLOSE_CYCLES (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .enter        (enter),
      .cancel       (cancel),
      .close_req    (close_req),
      .code_wr      (code_wr),
      .code_wr_data (code_wr_data),
      .open         (open),
      .close        (close),
      .locked_out   (locked_out),
      .fail_count   (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Outputs read after tick() reflect the inputs sampled on that edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
   endtask

   task automatic do_enter();
      enter = 1'b1;
      tick();
      enter = 1'b0;
   endtask

   task automatic do_close();
      close_req = 1'b1;
      tick();
      close_req = 1'b0;
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_open"},   {31'd0, open},       32'd0);
      chk({tag, "_close"},  {31'd0, close},      32'd0);
      chk({tag, "_locked"}, {31'd0, locked_out}, 32'd0);
      chk({tag, "_fail"},   {30'd0, fail_count}, 32'd0);
   endtask

   initial begin
      int unsigned n;
      logic        saw_open;

      rst = 1'b1; digit_valid = 1'b0; digit = '0; enter = 1'b0; cancel = 1'b0;
      close_req = 1'b0; code_wr = 1'b0; code_wr_data = '0;
      tick();
      tick();
      outputs_zero("reset");
      rst = 1'b0;

      // Correct code, then manual close on the 5th cycle of UNLOCKED.
      enter_code(16'h1234);
      chk("no_open_during_entry", {31'd0, open}, 32'd0);
      do_enter();
      chk("open_pulse", {31'd0, open}, 32'd1);
      chk("open_fail0", {30'd0, fail_count}, 32'd0);
      chk("open_no_close", {31'd0, close}, 32'd0);
      tick();
      chk("open_one_cycle", {31'd0, open}, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("no_early_close", {31'd0, close}, 32'd0);
      do_close();
      chk("close_req_pulse", {31'd0, close}, 32'd1);
      tick();
      chk("close_one_cycle", {31'd0, close}, 32'd0);

      // Three wrong codes -> lockout for 16 cycles; inputs ignored meanwhile.
      for (int k = 1; k <= 3; k++) begin
         enter_code(16'h1235);
         do_enter();
         chk("wrong_no_open", {31'd0, open}, 32'd0);
         chk("wrong_fail_count", {30'd0, fail_count}, 32'(k));
         chk("wrong_locked", {31'd0, locked_out}, (k == 3) ? 32'd1 : 32'd0);
      end
      n = 1;
      saw_open = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (j < 4) begin digit_valid = 1'b1; digit = 4'(j + 1); end
         if (j == 4) enter = 1'b1;
         if (j == 5) cancel = 1'b1;
         if (j == 6) begin close_req = 1'b1; code_wr = 1'b1; code_wr_data = 16'h9876; end
         tick();
         digit_valid = 1'b0; enter = 1'b0; cancel = 1'b0; close_req = 1'b0; code_wr = 1'b0;
         if (open) saw_open = 1'b1;
         if (locked_out) n++;
         else break;
      end
      chk("lockout_cycles", n, 32'd16);
      chk("lockout_no_open", {31'd0, saw_open}, 32'd0);
      chk("lockout_fail_cleared", {30'd0, fail_count}, 32'd0);
      enter_code(16'h1234);
      do_enter();
      chk("open_after_lockout", {31'd0, open}, 32'd1);
      do_close();
      chk("close_after_lockout", {31'd0, close}, 32'd1);

      // Fifth digit overflows; cancel discards a partial entry.
      enter_code(16'h1234);
      press(4'h4);
      do_enter();
      chk("overflow_no_open", {31'd0, open}, 32'd0);
      chk("overflow_fail", {30'd0, fail_count}, 32'd1);
      press(4'h1);
      press(4'h2);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("cancel_keeps_fail", {30'd0, fail_count}, 32'd1);
      enter_code(16'h1234);
      do_enter();
      chk("open_after_cancel", {31'd0, open}, 32'd1);
      chk("match_clears_fail", {30'd0, fail_count}, 32'd0);

      // Auto-close 32 cycles after entering UNLOCKED.
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (close) begin n = i; break; end
      end
      chk("auto_close_cycle", n, 32'd32);
      tick();
      chk("auto_close_one_cycle", {31'd0, close}, 32'd0);

      // Priority: enter beats digit_valid, cancel beats enter.
      enter_code(16'h1230);
      press(4'h1);
      enter_code(16'h0123);
      digit_valid = 1'b1; digit = 4'h4; enter = 1'b1;
      tick();
      digit_valid = 1'b0; enter = 1'b0;
      chk("enter_over_digit_open", {31'd0, open}, 32'd0);
      chk("enter_over_digit_fail", {30'd0, fail_count}, 32'd1);
      enter_code(16'h1234);
      cancel = 1'b1; enter = 1'b1;
      tick();
      cancel = 1'b0; enter = 1'b0;
      chk("cancel_over_enter_open", {31'd0, open}, 32'd0);
      chk("cancel_over_enter_fail", {30'd0, fail_count}, 32'd1);
      enter_code(16'h1234);
      do_enter();
      chk("open_after_priority", {31'd0, open}, 32'd1);

      // Code rewrite restarts the auto-close timer and changes the code.
      for (int i = 0; i < 10; i++) tick();
      code_wr = 1'b1; code_wr_data = 16'h9876;
      tick();
      code_wr = 1'b0;
      chk("code_wr_no_close", {31'd0, close}, 32'd0);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (close) begin n = i; break; end
      end
      chk("code_wr_timer_restart", n, 32'd32);
      enter_code(16'h1234);
      do_enter();
      chk("old_code_rejected", {31'd0, open}, 32'd0);
      chk("old_code_fail", {30'd0, fail_count}, 32'd1);
      enter_code(16'h9876);
      do_enter();
      chk("new_code_open", {31'd0, open}, 32'd1);
      close_req = 1'b1; code_wr = 1'b1; code_wr_data = 16'h1234;
      tick();
      close_req = 1'b0; code_wr = 1'b0;
      chk("close_with_code_wr", {31'd0, close}, 32'd1);
      code_wr = 1'b1; code_wr_data = 16'hAAAA;
      tick();
      code_wr = 1'b0;
      enter_code(16'h1234);
      do_enter();
      chk("code_wr_ignored_idle", {31'd0, open}, 32'd1);

      // Reset mid-entry restores the default code.
      code_wr = 1'b1; code_wr_data = 16'h9876;
      tick();
      code_wr = 1'b0;
      do_close();
      press(4'h9);
      press(4'h8);
      rst = 1'b1;
      tick();
      outputs_zero("rst_mid_entry");
      rst = 1'b0;
      enter_code(16'h9876);
      do_enter();
      chk("rst_code_restored_rej", {31'd0, open}, 32'd0);
      enter_code(16'h1234);
      do_enter();
      chk("rst_default_code_open", {31'd0, open}, 32'd1);
      do_close();

      // Reset mid-lockout.
      for (int k = 0; k < 3; k++) begin
         enter_code(16'h4321);
         do_enter();
      end
      chk("lockout_again", {31'd0, locked_out}, 32'd1);
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      outputs_zero("rst_mid_lockout");
      rst = 1'b0;
      enter_code(16'h1234);
      do_enter();
      chk("open_after_rst_lockout", {31'd0, open}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
